// File: rtl/spu_pkg.sv
// Shared constants for the Mini SPU instruction sequencer: route codes,
// sequencer state encoding and instruction-word field positions.
package spu_pkg;

   // Instruction word layout: upper nibble routes the mux, lower nibble is the opcode.
   localparam int INSTR_W = 8;
   localparam int Q_HI    = 7;
   localparam int Q_LO    = 4;
   localparam int OP_HI   = 3;
   localparam int OP_LO   = 0;

   // Route codes understood by the downstream mux; NoIO is the parked value.
   localparam logic [3:0] Q_NOIO = 4'b0000;
   localparam logic [3:0] Q_ZERO = 4'b0001;
   localparam logic [3:0] Q_UIO  = 4'b0010;
   localparam logic [3:0] Q_MN   = 4'b0100;

   // Idle opcode driven whenever the mux is parked.
   localparam logic [3:0] OP_NOP = 4'b0000;

   // Sequencer states.
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   // Extract the routing code from an instruction word.
   function automatic logic [3:0] instr_q(input logic [INSTR_W-1:0] word);
      return word[Q_HI:Q_LO];
   endfunction

   // Extract the compute opcode from an instruction word.
   function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] word);
      return word[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/spu_prog_mem.sv
// Program buffer: DEPTH x IW register file, synchronous write, combinational
// read addressed by the sequencer pc. Contents are deliberately not reset;
// the sequencer's prog_len gates which slots are reachable.
module spu_prog_mem #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int IW    = 8
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [IW-1:0]    wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [IW-1:0]    rd_data
);

   logic [IW-1:0] mem_r [DEPTH];

   // Append one instruction word at the write pointer.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/spu_sequencer.sv
// Instruction sequencer feeding the Mini SPU routing mux. Loads a short
// program serially, replays it loop_count+1 times back to back, then parks
// the mux on NoIO and pulses done.
module spu_sequencer
   import spu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int IW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             load_en,
   input  logic [IW-1:0]    load_data,
   input  logic             clear,
   input  logic             start,
   input  logic             abort,
   input  logic [3:0]       loop_count,
   output logic [3:0]       q_out,
   output logic [3:0]       op_out,
   output logic             busy,
   output logic             done,
   output logic             full,
   output logic [PTR_W:0]   prog_len
);

   localparam logic [PTR_W:0]   LEN_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   LEN_DEPTH = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PC_ONE    = PTR_W'(1);

   logic [1:0]       state_r;
   logic [PTR_W-1:0] pc_r;
   logic [3:0]       loops_left_r;
   logic [PTR_W:0]   prog_len_r;
   logic [3:0]       q_r;
   logic [3:0]       op_r;
   logic             done_r;

   logic             full_s;
   logic             last_s;
   logic             wr_en_s;
   logic [IW-1:0]    rd_data_s;

   assign full_s = (prog_len_r == LEN_DEPTH);
   assign last_s = ({1'b0, pc_r} == (prog_len_r - LEN_ONE));

   // A load only lands in IDLE and loses to clear and start in the same cycle.
   assign wr_en_s = ena && (state_r == S_IDLE) && !clear && !start && load_en && !full_s;

   spu_prog_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .IW    (IW)
   ) u_prog_mem (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (prog_len_r[PTR_W-1:0]),
      .wr_data (load_data),
      .rd_addr (pc_r),
      .rd_data (rd_data_s)
   );

   // Sequencer FSM: loading/arming in IDLE, issuing in RUN, done pulse in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         pc_r         <= '0;
         loops_left_r <= 4'd0;
         prog_len_r   <= '0;
         q_r          <= Q_NOIO;
         op_r         <= OP_NOP;
         done_r       <= 1'b0;
      end else if (ena) begin
         case (state_r)
            S_IDLE: begin
               q_r    <= Q_NOIO;
               op_r   <= OP_NOP;
               done_r <= 1'b0;
               if (clear) begin
                  prog_len_r <= '0;
               end else if (start) begin
                  // An empty program cannot be started.
                  if (prog_len_r != '0) begin
                     pc_r         <= '0;
                     loops_left_r <= loop_count;
                     state_r      <= S_RUN;
                  end
               end else if (load_en && !full_s) begin
                  prog_len_r <= prog_len_r + LEN_ONE;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_r <= S_IDLE;
                  q_r     <= Q_NOIO;
                  op_r    <= OP_NOP;
                  done_r  <= 1'b0;
               end else begin
                  q_r  <= instr_q(rd_data_s);
                  op_r <= instr_op(rd_data_s);
                  if (last_s) begin
                     if (loops_left_r == 4'd0) begin
                        state_r <= S_DONE;
                     end else begin
                        // Wrap to the first slot with no bubble.
                        loops_left_r <= loops_left_r - 4'd1;
                        pc_r         <= '0;
                     end
                  end else begin
                     pc_r <= pc_r + PC_ONE;
                  end
               end
            end
            S_DONE: begin
               q_r     <= Q_NOIO;
               op_r    <= OP_NOP;
               done_r  <= 1'b1;
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
               q_r     <= Q_NOIO;
               op_r    <= OP_NOP;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign q_out    = q_r;
   assign op_out   = op_r;
   assign done     = done_r;
   assign busy     = (state_r == S_RUN) || (state_r == S_DONE);
   assign full     = full_s;
   assign prog_len = prog_len_r;

endmodule

// File: tb/tb_spu_sequencer.sv
// Self-checking bench for spu_sequencer. A stream model turns each accepted
// start into the full queue of expected output tuples; a negedge process
// compares the DUT against the current tuple every cycle, and directed
// literal checks pin the model at key points.
module tb_spu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       load_en;
   logic [7:0] load_data;
   logic       clear;
   logic       start;
   logic       abort;
   logic [3:0] loop_count;
   logic [3:0] q_out;
   logic [3:0] op_out;
   logic       busy;
   logic       done;
   logic       full;
   logic [3:0] prog_len;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: buffer image, length, expected {q,op,busy,done} stream.
   logic [7:0] mmem [8];
   int         mlen = 0;
   logic [9:0] exp_q [$];
   logic [9:0] cur_exp = 10'b0;

   always #5 clk = ~clk;

   spu_sequencer #(.DEPTH(8), .PTR_W(3), .IW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .load_en    (load_en),
      .load_data  (load_data),
      .clear      (clear),
      .start      (start),
      .abort      (abort),
      .loop_count (loop_count),
      .q_out      (q_out),
      .op_out     (op_out),
      .busy       (busy),
      .done       (done),
      .full       (full),
      .prog_len   (prog_len)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Per-cycle comparison against the model's current expected tuple.
   always @(negedge clk) begin
      chk("cyc_q",     {28'd0, q_out},  {28'd0, cur_exp[9:6]});
      chk("cyc_op",    {28'd0, op_out}, {28'd0, cur_exp[5:2]});
      chk("cyc_busy",  {31'd0, busy},   {31'd0, cur_exp[1]});
      chk("cyc_done",  {31'd0, done},   {31'd0, cur_exp[0]});
      chk("cyc_len",   {28'd0, prog_len}, mlen);
      chk("cyc_full",  {31'd0, full},   {31'd0, (mlen == 8)});
   end

   // Whole run as seen on the outputs: arm cycle, every word of every pass, done.
   task automatic push_run(input logic [3:0] lc);
      exp_q.push_back({8'h00, 1'b1, 1'b0});
      for (int p = 0; p <= int'(lc); p++) begin
         for (int i = 0; i < mlen; i++) begin
            exp_q.push_back({mmem[i], 1'b1, 1'b0});
         end
      end
      exp_q.push_back({8'h00, 1'b0, 1'b1});
   endtask

   // One clock edge; afterwards apply the sampled inputs to the model.
   task automatic tick();
      logic       e  = ena;
      logic       ld = load_en;
      logic       cl = clear;
      logic       st = start;
      logic       ab = abort;
      logic       r  = rst_n;
      logic [7:0] d  = load_data;
      logic [3:0] lc = loop_count;
      @(posedge clk);
      #1;
      if (r && e) begin
         if (exp_q.size() == 0) begin
            if (cl) mlen = 0;
            else if (st) begin
               if (mlen > 0) push_run(lc);
            end else if (ld && mlen < 8) begin
               mmem[mlen] = d;
               mlen++;
            end
         end else if (ab && exp_q.size() >= 2) begin
            exp_q.delete();
         end
         cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'b0;
      end
      load_en = 1'b0;
      clear   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
   endtask

   task automatic load_word(input logic [7:0] d);
      load_data = d;
      load_en   = 1'b1;
      tick();
   endtask

   task automatic start_run(input logic [3:0] lc);
      loop_count = lc;
      start      = 1'b1;
      tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
   endtask

   // Edges until done, bounded; a timeout shows up as a wrong count.
   task automatic wait_done(input string name, input int expected);
      int c = 0;
      do begin
         tick();
         c++;
      end while (done !== 1'b1 && c < 40);
      chk(name, c, expected);
   endtask

   task automatic load3();
      load_word(8'h4A);
      load_word(8'h5B);
      load_word(8'h8C);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; load_en = 1'b0; load_data = 8'h00;
      clear = 1'b0; start = 1'b0; abort = 1'b0; loop_count = 4'd0;
      #2;
      chk("rst_q", q_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_len", prog_len, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic three-word single pass.
      load3();
      chk("len3", prog_len, 3);
      start_run(4'd0);
      chk("arm_busy", busy, 1);
      chk("arm_q", q_out, 0);
      tick(); chk("w0_q", q_out, 4'h4); chk("w0_op", op_out, 4'hA);
      tick(); chk("w1_q", q_out, 4'h5); chk("w1_op", op_out, 4'hB);
      tick(); chk("w2_q", q_out, 4'h8); chk("w2_op", op_out, 4'hC); chk("w2_busy", busy, 1);
      tick(); chk("end_q", q_out, 0); chk("end_done", done, 1); chk("end_busy", busy, 0);
      tick(); chk("post_done", done, 0);

      // Same program, three passes, no gap at the wrap.
      start_run(4'd2);
      wait_done("loop3_len", 10);
      tick();

      // Overfill: only eight words land.
      do_clear();
      for (int i = 0; i < 10; i++) begin
         load_word(8'h90 + 8'(i));
         if (i == 6) chk("full_at7", full, 0);
         if (i == 7) begin
            chk("full_at8", full, 1);
            chk("len_at8", prog_len, 8);
         end
      end
      chk("len_after10", prog_len, 8);
      start_run(4'd0);
      wait_done("full_run_len", 9);
      tick();

      // Abort on the second RUN cycle, then replay from slot 0.
      do_clear();
      load3();
      start_run(4'd0);
      tick();
      abort = 1'b1;
      tick();
      chk("abort_q", q_out, 0);
      chk("abort_busy", busy, 0);
      repeat (4) begin
         tick();
         chk("abort_nodone", done, 0);
      end
      start_run(4'd0);
      tick();
      chk("replay_q", q_out, 4'h4);
      chk("replay_op", op_out, 4'hA);
      wait_done("replay_rest", 3);
      tick();

      // Empty start ignored; clear beats load; single-word program repeats.
      do_clear();
      start_run(4'd0);
      chk("empty_start_busy", busy, 0);
      tick();
      chk("empty_start_busy2", busy, 0);
      load_data = 8'h77; load_en = 1'b1; clear = 1'b1;
      tick();
      chk("clear_beats_load", prog_len, 0);
      load_word(8'h2D);
      start_run(4'd3);
      tick();
      chk("single_q", q_out, 4'h2);
      chk("single_op", op_out, 4'hD);
      wait_done("single_rest", 4);
      tick();

      // Asynchronous reset mid-run.
      load3();
      start_run(4'd0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      mlen = 0;
      cur_exp = 10'b0;
      #1;
      chk("arst_q", q_out, 0);
      chk("arst_op", op_out, 0);
      chk("arst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("arst_len", prog_len, 0);

      // Enable held low mid-run freezes outputs; nothing is skipped.
      load3();
      start_run(4'd1);
      tick();
      tick();
      chk("pre_freeze_q", q_out, 4'h5);
      ena = 1'b0;
      repeat (3) begin
         tick();
         chk("freeze_q", q_out, 4'h5);
         chk("freeze_op", op_out, 4'hB);
      end
      ena = 1'b1;
      tick();
      chk("resume_q", q_out, 4'h8);
      chk("resume_op", op_out, 4'hC);
      wait_done("resume_rest", 4);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
